// File: rtl/rti_issue_ctrl.sv
// rti_issue_ctrl: collects NUM_OPS FP32 operand words, launches one
// ray/triangle intersection job, waits for the result and holds it until
// the consumer takes it.
//
// Optional build macro: RTI_TIMEOUT_EN adds a WAIT-state watchdog that forces
// a quiet-NaN result and an error pulse after TIMEOUT_CYCLES idle WAIT cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_COLLECT | accept operand writes; start launches once all slots loaded
// ST_LAUNCH  | one-cycle input_valid_o strobe to the intersection unit
// ST_WAIT    | wait for output_valid_i (or watchdog expiry)
// ST_RESULT  | hold result until result_valid_o & result_ready_i
module rti_issue_ctrl #(
    parameter int NUM_OPS        = 15,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid_i,
    input  logic [3:0]              wr_idx_i,
    input  logic [31:0]             wr_data_i,
    output logic                    wr_ready_o,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic [NUM_OPS-1:0][31:0] fprti_regs_o,
    output logic                    input_valid_o,
    input  logic [31:0]             return_i,
    input  logic                    output_valid_i,
    output logic [31:0]             result_o,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic                    error_o
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NUM_OPS-1:0]       r_mask;
    logic [NUM_OPS-1:0][31:0] r_bank;
    logic [31:0]              r_result;
    logic                     r_error;
    logic                     w_error_nxt;
    logic                     w_wr_acc;
    logic                     w_wr_inrange;
    logic                     w_wr_ok;
    logic [NUM_OPS-1:0]       w_wr_onehot;
    logic [NUM_OPS-1:0]       w_mask_sum;
    logic                     w_timeout;
    logic                     w_handshake;

    // wr_ready_o is forced low while reset is held so nothing is accepted
    assign wr_ready_o   = (r_state == ST_COLLECT) && rst_n;
    assign w_wr_acc     = wr_valid_i && wr_ready_o;
    assign w_wr_inrange = (int'(wr_idx_i) < NUM_OPS);
    assign w_wr_ok      = w_wr_acc && w_wr_inrange;
    assign w_handshake  = (r_state == ST_RESULT) && result_ready_i;

    // One-hot of the slot being written this cycle (zero if none/invalid)
    always_comb begin
        w_wr_onehot = '0;
        if (w_wr_ok) begin
            w_wr_onehot[wr_idx_i] = 1'b1;
        end
    end

    // Start is judged against the mask as it will be after this cycle's write
    assign w_mask_sum = r_mask | w_wr_onehot;

`ifdef RTI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait_cnt;

    // Counts WAIT cycles; held at zero outside WAIT so every entry starts fresh
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Fires on the WAIT cycle whose edge brings the count to TIMEOUT_CYCLES
    assign w_timeout = (r_state == ST_WAIT) &&
                       (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: the parameter only keeps both builds on one interface
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and error-pulse decode
    always_comb begin
        w_state_nxt = r_state;
        w_error_nxt = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_wr_acc && !w_wr_inrange) begin
                    w_error_nxt = 1'b1;
                end
                if (start_i) begin
                    if (&w_mask_sum) begin
                        w_state_nxt = ST_LAUNCH;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (output_valid_i) begin
                    w_state_nxt = ST_RESULT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESULT;
                    w_error_nxt = 1'b1;
                end
            end
            ST_RESULT: begin
                if (result_ready_i) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    // Operand bank, loaded mask, result capture and error pulse register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bank   <= '0;
            r_mask   <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error <= w_error_nxt;
            if (w_wr_ok) begin
                r_bank[wr_idx_i] <= wr_data_i;
            end
            if (w_handshake) begin
                r_mask <= '0;
            end else begin
                r_mask <= w_mask_sum;
            end
            if (r_state == ST_WAIT) begin
                if (output_valid_i) begin
                    r_result <= return_i;
                end else if (w_timeout) begin
                    r_result <= QNAN;
                end
            end
        end
    end

    assign fprti_regs_o   = r_bank;
    assign input_valid_o  = (r_state == ST_LAUNCH);
    assign busy_o         = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
    assign result_valid_o = (r_state == ST_RESULT);
    assign result_o       = r_result;
    assign error_o        = r_error;

endmodule

// File: tb/tb_rti_issue_ctrl.sv
// Directed bench for rti_issue_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled at that same point, well clear of the edge.
module tb_rti_issue_ctrl;

    localparam int NUM_OPS = 15;
    localparam int TMO     = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     wr_valid_i;
    logic [3:0]               wr_idx_i;
    logic [31:0]              wr_data_i;
    logic                     wr_ready_o;
    logic                     start_i;
    logic                     busy_o;
    logic [NUM_OPS-1:0][31:0] fprti_regs_o;
    logic                     input_valid_o;
    logic [31:0]              return_i;
    logic                     output_valid_i;
    logic [31:0]              result_o;
    logic                     result_valid_o;
    logic                     result_ready_i;
    logic                     error_o;

    int n_checks = 0;
    int n_errors = 0;

    rti_issue_ctrl #(
        .NUM_OPS        (NUM_OPS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid_i     (wr_valid_i),
        .wr_idx_i       (wr_idx_i),
        .wr_data_i      (wr_data_i),
        .wr_ready_o     (wr_ready_o),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .fprti_regs_o   (fprti_regs_o),
        .input_valid_o  (input_valid_o),
        .return_i       (return_i),
        .output_valid_i (output_valid_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .error_o        (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] d);
        wr_valid_i = 1'b1;
        wr_idx_i   = idx;
        wr_data_i  = d;
        step();
        wr_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    int bad;
    int seen;

    initial begin
        rst_n = 1'b0; wr_valid_i = 1'b0; wr_idx_i = '0; wr_data_i = '0;
        start_i = 1'b0; return_i = '0; output_valid_i = 1'b0; result_ready_i = 1'b0;
        step(); step(); step();

        // reset state
        chk("rst_wr_ready", {31'b0, wr_ready_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_rvalid", {31'b0, result_valid_o}, 0);
        chk("rst_ivalid", {31'b0, input_valid_o}, 0);
        chk("rst_error", {31'b0, error_o}, 0);
        chk("rst_result", result_o, 0);
        chk("rst_bank0", fprti_regs_o[0], 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_wr_ready", {31'b0, wr_ready_o}, 1);

        // full job
        for (int i = 0; i < NUM_OPS; i++) wr(4'(i), 32'h3F80_0000 + i);
        pulse_start();
        chk("launch_ivalid", {31'b0, input_valid_o}, 1);
        chk("launch_busy", {31'b0, busy_o}, 1);
        chk("launch_wr_ready", {31'b0, wr_ready_o}, 0);
        chk("launch_err", {31'b0, error_o}, 0);
        chk("launch_bank14", fprti_regs_o[14], 32'h3F80_000E);
        chk("launch_bank0", fprti_regs_o[0], 32'h3F80_0000);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (input_valid_o) seen++;
        end
        chk("ivalid_one_cycle", seen, 0);
        chk("wait_busy", {31'b0, busy_o}, 1);
        output_valid_i = 1'b1; return_i = 32'h4049_0FDB;
        chk("rvalid_before", {31'b0, result_valid_o}, 0);
        step();
        output_valid_i = 1'b0; return_i = '0;
        chk("rvalid_after", {31'b0, result_valid_o}, 1);
        chk("result_val", result_o, 32'h4049_0FDB);
        chk("result_busy", {31'b0, busy_o}, 0);

        // hold in RESULT with stray start/output_valid
        bad = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin output_valid_i = 1'b1; return_i = 32'hAAAA_5555; end
            if (i == 5) start_i = 1'b1;
            step();
            output_valid_i = 1'b0; start_i = 1'b0;
            if (result_valid_o !== 1'b1 || result_o !== 32'h4049_0FDB || wr_ready_o !== 1'b0) bad++;
            if (error_o) seen++;
        end
        chk("result_hold", bad, 0);
        chk("result_hold_err", seen, 0);
        chk("hold_bank14", fprti_regs_o[14], 32'h3F80_000E);
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        chk("hs_wr_ready", {31'b0, wr_ready_o}, 1);
        chk("hs_rvalid", {31'b0, result_valid_o}, 0);
        chk("hs_bank3", fprti_regs_o[3], 32'h3F80_0003);
        pulse_start();
        chk("mask_clr_err", {31'b0, error_o}, 1);
        chk("mask_clr_ivalid", {31'b0, input_valid_o}, 0);

        // partial load then start
        for (int i = 0; i < 14; i++) wr(4'(i), 32'h4000_0000 + i);
        chk("partial_err_idle", {31'b0, error_o}, 0);
        pulse_start();
        chk("partial_err", {31'b0, error_o}, 1);
        chk("partial_ivalid", {31'b0, input_valid_o}, 0);
        chk("partial_wr_ready", {31'b0, wr_ready_o}, 1);
        step();
        chk("partial_err_once", {31'b0, error_o}, 0);
        chk("partial_ivalid2", {31'b0, input_valid_o}, 0);

        // out-of-range write
        wr(4'd15, 32'hDEAD_BEEF);
        chk("oor_err", {31'b0, error_o}, 1);
        bad = 0;
        for (int i = 0; i < NUM_OPS; i++) if (fprti_regs_o[i] == 32'hDEAD_BEEF) bad++;
        chk("oor_no_slot", bad, 0);
        chk("oor_bank14", fprti_regs_o[14], 32'h3F80_000E);
        step();
        pulse_start();
        chk("oor_mask_err", {31'b0, error_o}, 1);
        chk("oor_mask_ivalid", {31'b0, input_valid_o}, 0);

        // write of last slot and start in the same cycle
        wr_valid_i = 1'b1; wr_idx_i = 4'd14; wr_data_i = 32'h1234_5678; start_i = 1'b1;
        step();
        wr_valid_i = 1'b0; start_i = 1'b0;
        chk("same_cyc_ivalid", {31'b0, input_valid_o}, 1);
        chk("same_cyc_bank14", fprti_regs_o[14], 32'h1234_5678);
        chk("same_cyc_bank13", fprti_regs_o[13], 32'h4000_000D);
        chk("same_cyc_err", {31'b0, error_o}, 0);

`ifdef RTI_TIMEOUT_EN
        // watchdog: 8 WAIT cycles with no result
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (result_valid_o) seen = i + 1;
        end
        chk("tmo_latency", seen, TMO + 1);
        chk("tmo_result", result_o, 32'h7FC0_0000);
        chk("tmo_err", {31'b0, error_o}, 1);
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        chk("tmo_back_collect", {31'b0, wr_ready_o}, 1);
        for (int i = 0; i < NUM_OPS; i++) wr(4'(i), 32'h3F80_0000 + i);
        pulse_start();
`endif

        // reset during WAIT abandons the job
        step(); step();
        chk("pre_rst_busy", {31'b0, busy_o}, 1);
        rst_n = 1'b0;
        step();
        chk("in_rst_wr_ready", {31'b0, wr_ready_o}, 0);
        chk("in_rst_busy", {31'b0, busy_o}, 0);
        step();
        rst_n = 1'b1;
        output_valid_i = 1'b1; return_i = 32'h1111_2222;
        step();
        output_valid_i = 1'b0;
        step();
        chk("rst_wait_rvalid", {31'b0, result_valid_o}, 0);
        chk("rst_wait_result", result_o, 0);
        chk("rst_wait_wr_ready", {31'b0, wr_ready_o}, 1);
        chk("rst_wait_bank14", fprti_regs_o[14], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
